// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 z-buffer read path.
package gfx256_pkg;

  // Line address: a 256-bit (32-byte) memory line, so bits [4:0] are implied zero.
  typedef logic [31:5] line_addr_t;

  // One 256-bit z-buffer line.
  typedef logic [255:0] zline_t;

  // Responder states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } zrd_state_t;

  // Data returned on a failed read. A z of 0 always passes the depth test, so
  // a failed read leads to the pixel being drawn instead of silently lost.
  localparam zline_t ZRD_ERR_DATA = 256'h0;

endpackage : gfx256_pkg

// File: rtl/gfx256_zline_cache.sv
// One-line z-buffer cache: valid bit, line tag and 256 data bits.
// Built only when GFX256_ZREAD_LINE_CACHE_EN is defined.
// A matching write notification always beats a hit check in the same cycle,
// so the requester never sees a line that is being overwritten.
module gfx256_zline_cache
  import gfx256_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  // Hit check for the request in IDLE.
  input  logic [31:5]  lookup_addr_i,
  output logic         hit_o,
  output logic [255:0] data_o,
  // Successful bus read: refill the line.
  input  logic         fill_i,
  input  logic [31:5]  fill_addr_i,
  input  logic [255:0] fill_data_i,
  // Failed or timed-out bus read: forget the line.
  input  logic         drop_i,
  // Write notification for a z line.
  input  logic         inval_i,
  input  logic [31:5]  inval_addr_i
);

  logic       valid_q;
  logic       valid_d;
  line_addr_t tag_q;
  zline_t     line_q;
  logic       inval_match;
  logic       fill_inval;

  assign inval_match = inval_i && valid_q && (inval_addr_i == tag_q);
  // A write to the line being fetched makes the fetched data stale already.
  assign fill_inval  = inval_i && (inval_addr_i == fill_addr_i);

  assign hit_o  = valid_q && (lookup_addr_i == tag_q) && !inval_match;
  assign data_o = line_q;

  // Next valid bit: refill sets it, invalidation and failed reads clear it.
  always_comb begin
    valid_d = valid_q;
    if (inval_match || drop_i) begin
      valid_d = 1'b0;
    end
    if (fill_i) begin
      valid_d = !fill_inval;
    end
  end

  // Valid bit: the only cache state that needs a defined value after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and line storage, written on refill.
  // NOTE: tag/data carry no reset; they are only read while valid_q is set.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q  <= fill_addr_i;
      line_q <= fill_data_i;
    end
  end

endmodule : gfx256_zline_cache

// File: rtl/gfx256_zbuf_reader.sv
// Z-buffer read responder: turns each depth-test request into one Wishbone
// classic read of a 256-bit line and returns it with a one-cycle ack.
// Optional macro: GFX256_ZREAD_LINE_CACHE_EN adds a one-line cache that serves
// repeated reads of the same line without a bus cycle.
module gfx256_zbuf_reader
  import gfx256_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,  // 0 disables the timeout
  parameter int unsigned TO_W           = 8     // 2**TO_W > TIMEOUT_CYCLES
) (
  input  logic         clk_i,
  input  logic         rst_i,
  // Requester side
  input  logic         req_i,
  input  logic [31:5]  addr_i,
  input  logic [31:0]  sel_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o,
  output logic         err_o,
  // Bus side
  input  logic         bus_busy_i,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  output logic         wb_we_o,
  output logic [31:5]  wb_adr_o,
  output logic [31:0]  wb_sel_o,
  input  logic [255:0] wb_dat_i,
  input  logic         wb_ack_i,
  input  logic         wb_err_i,
  // Z-line write notification
  input  logic         inval_i,
  input  logic [31:5]  inval_addr_i
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // The abort fires in the last allowed bus cycle, so the read sees exactly
  // TIMEOUT_CYCLES cycles of wb_cyc_o before the error ack.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  zrd_state_t      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  zline_t          data_q, data_d;
  logic            busy_q;
  logic            cyc_q, cyc_d;
  line_addr_t      adr_q, adr_d;
  logic [31:0]     sel_q, sel_d;

  logic            timeout_hit;
  logic            bus_ok;
  logic            bus_fail;
  logic            cache_hit;
  zline_t          cache_data;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == TO_LAST);

`ifdef GFX256_ZREAD_LINE_CACHE_EN
  gfx256_zline_cache u_cache (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lookup_addr_i (addr_i),
    .hit_o         (cache_hit),
    .data_o        (cache_data),
    .fill_i        (bus_ok),
    .fill_addr_i   (adr_q),
    .fill_data_i   (wb_dat_i),
    .drop_i        (bus_fail),
    .inval_i       (inval_i),
    .inval_addr_i  (inval_addr_i)
  );
`else
  logic unused_inval;

  assign cache_hit    = 1'b0;
  assign cache_data   = ZRD_ERR_DATA;
  assign unused_inval = inval_i ^ (^inval_addr_i);
`endif

  // Next-state and output decode for the request/bus handshake.
  // NOTE: every comb output gets a default first, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    data_d   = data_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    bus_ok   = 1'b0;
    bus_fail = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (cache_hit) begin
            // Hit needs no bus, so bus_busy_i does not matter here.
            data_d  = cache_data;
            ack_d   = 1'b1;
            state_d = DONE;
          end else if (!bus_busy_i) begin
            adr_d   = addr_i;
            sel_d   = sel_i;
            cyc_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end

      BUS: begin
        // Error wins over a simultaneous ack; a real ack wins over the timeout.
        if (wb_err_i) begin
          bus_fail = 1'b1;
        end else if (wb_ack_i) begin
          bus_ok = 1'b1;
        end else if (timeout_hit) begin
          bus_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end

        if (bus_ok) begin
          data_d  = wb_dat_i;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = DONE;
        end else if (bus_fail) begin
          data_d  = ZRD_ERR_DATA;
          cyc_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      // Guard cycle: the requester drops req_i on the edge where it samples
      // ack_o, so req_i is ignored here to avoid a duplicate read.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
      busy_q  <= (state_d != IDLE) || bus_busy_i;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
    end
  end

  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign data_o   = data_q;
  assign busy_o   = busy_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = 1'b0;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;

endmodule : gfx256_zbuf_reader

// File: tb/tb_gfx256_zbuf_reader.sv
// Self-checking bench for gfx256_zbuf_reader with a behavioural Wishbone slave
// and a transaction-level reference model (expected data, latency, bus usage,
// and the one-line cache contents when GFX256_ZREAD_LINE_CACHE_EN is defined).
module tb_gfx256_zbuf_reader;
  import gfx256_pkg::*;

  localparam int TO = 255;

`ifdef GFX256_ZREAD_LINE_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  // Slave behaviours
  localparam int M_ACK   = 0;
  localparam int M_ERR   = 1;
  localparam int M_NEVER = 2;
  localparam int M_BOTH  = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_i;
  logic [31:5]  addr_i;
  logic [31:0]  sel_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;
  logic         err_o;
  logic         bus_busy_i;
  logic         wb_cyc_o;
  logic         wb_stb_o;
  logic         wb_we_o;
  logic [31:5]  wb_adr_o;
  logic [31:0]  wb_sel_o;
  logic [255:0] wb_dat_i;
  logic         wb_ack_i;
  logic         wb_err_i;
  logic         inval_i;
  logic [31:5]  inval_addr_i;

  int checks   = 0;
  int failures = 0;

  // Slave configuration, set by the stimulus before each request.
  int           s_delay = 0;
  int           s_mode  = M_ACK;
  logic [255:0] s_dat   = '0;
  int           s_cnt   = 0;

  // Reference model of the cache line.
  bit           m_valid = 1'b0;
  logic [31:5]  m_tag   = '0;
  logic [255:0] m_data  = '0;

  gfx256_zbuf_reader #(
    .TIMEOUT_CYCLES (TO),
    .TO_W           (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .sel_i        (sel_i),
    .ack_o        (ack_o),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .bus_busy_i   (bus_busy_i),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_sel_o     (wb_sel_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .inval_i      (inval_i),
    .inval_addr_i (inval_addr_i)
  );

  always #5 clk_i = ~clk_i;

  // Wishbone slave: responds in bus cycle s_delay+1 of an active cycle.
  always @(negedge clk_i) begin
    if (wb_cyc_o && wb_stb_o) begin
      s_cnt++;
      wb_ack_i = ((s_mode == M_ACK) || (s_mode == M_BOTH)) && (s_cnt == s_delay + 1);
      wb_err_i = ((s_mode == M_ERR) || (s_mode == M_BOTH)) && (s_cnt == s_delay + 1);
    end else begin
      s_cnt    = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
    wb_dat_i = s_dat;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request. Latency counts clock edges from the first edge that
  // can accept the request until ack_o is seen: 1 for a cache hit, d+2 for a
  // bus read whose slave waits d cycles, TO+1 for a timeout.
  task automatic do_read(input string tag, input logic [31:5] a, input logic [31:0] s,
                         input logic [255:0] dat, input int d, input int mode,
                         input int busy_cyc);
    logic [255:0] exp_data;
    bit           exp_err;
    bit           exp_hit;
    int           exp_lat;
    int           exp_cyc;
    int           lat;
    int           cyc_cycles;
    int           rises;
    bit           prev_cyc;
    bit           done;
    bit           bus_sig_ok;

    exp_hit = CACHE_EN && m_valid && (a == m_tag);
    if (exp_hit) begin
      exp_data = m_data;
      exp_err  = 1'b0;
      exp_cyc  = 0;
      exp_lat  = 1;
    end else if (mode == M_NEVER) begin
      exp_data = '0;
      exp_err  = 1'b1;
      exp_cyc  = TO;
      exp_lat  = TO + 1;
    end else begin
      exp_err  = (mode != M_ACK);
      exp_data = exp_err ? 256'h0 : dat;
      exp_cyc  = d + 1;
      exp_lat  = d + 2;
    end

    @(negedge clk_i);
    s_dat      = dat;
    s_delay    = d;
    s_mode     = mode;
    addr_i     = a;
    sel_i      = s;
    req_i      = 1'b1;
    bus_busy_i = (busy_cyc > 0);

    if (busy_cyc > 0) begin
      for (int i = 0; i < busy_cyc; i++) begin
        @(posedge clk_i);
        #1;
        check({tag, ":cyc_while_bus_busy"}, wb_cyc_o, 1'b0);
      end
      check({tag, ":busy_o_while_waiting"}, busy_o, 1'b1);
      @(negedge clk_i);
      bus_busy_i = 1'b0;
    end

    lat        = 0;
    cyc_cycles = 0;
    rises      = 0;
    prev_cyc   = 1'b0;
    done       = 1'b0;
    bus_sig_ok = 1'b1;
    while (!done && lat < TO + 20) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (wb_cyc_o) begin
        cyc_cycles++;
        if (!prev_cyc) rises++;
        if (wb_adr_o !== a || wb_sel_o !== s || wb_stb_o !== 1'b1 || wb_we_o !== 1'b0)
          bus_sig_ok = 1'b0;
      end
      prev_cyc = wb_cyc_o;
      if (ack_o) done = 1'b1;
    end

    check({tag, ":ack_seen"}, done, 1'b1);
    check({tag, ":latency"}, 256'(lat), 256'(exp_lat));
    check({tag, ":data_o"}, data_o, exp_data);
    check({tag, ":err_o"}, err_o, exp_err);
    check({tag, ":bus_cycles"}, 256'(cyc_cycles), 256'(exp_cyc));
    check({tag, ":cyc_rises"}, 256'(rises), exp_hit ? 256'd0 : 256'd1);
    check({tag, ":bus_signals"}, bus_sig_ok, 1'b1);

    // The requester drops req_i on the edge where it saw ack_o.
    req_i = 1'b0;
    @(posedge clk_i);
    #1;
    check({tag, ":ack_single_cycle"}, {ack_o, err_o, wb_cyc_o}, 3'b000);
    check({tag, ":data_held"}, data_o, exp_data);

    if (CACHE_EN && !exp_hit) begin
      if (exp_err) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_tag   = a;
        m_data  = dat;
      end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    req_i        = 1'b0;
    addr_i       = '0;
    sel_i        = '0;
    bus_busy_i   = 1'b0;
    wb_dat_i     = '0;
    wb_ack_i     = 1'b0;
    wb_err_i     = 1'b0;
    inval_i      = 1'b0;
    inval_addr_i = '0;

    // Reset values
    #2;
    check("reset:ack_err_busy", {ack_o, err_o, busy_o}, 3'b000);
    check("reset:data_o", data_o, 256'h0);
    check("reset:wb_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("reset:wb_adr_o", wb_adr_o, 27'h0);
    check("reset:wb_sel_o", wb_sel_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Single read, slave acks in the third bus cycle
    do_read("single", 27'h0000123, 32'hFFFF_FFFF, {32{8'hA5}}, 2, M_ACK, 0);

    // Request held while another master owns the bus
    do_read("bus_busy", 27'h0000200, $urandom(), {8{$urandom()}}, 0, M_ACK, 5);

    // Error on the first bus cycle
    do_read("err_first", 27'h0000300, $urandom(), {8{$urandom()}}, 0, M_ERR, 0);

    // Error and ack together: error wins
    do_read("err_and_ack", 27'h0000310, $urandom(), {8{$urandom()}}, 1, M_BOTH, 0);

    // Slave never answers
    do_read("timeout", 27'h0000400, $urandom(), {8{$urandom()}}, 0, M_NEVER, 0);

    // Reset in the middle of a bus cycle
    @(negedge clk_i);
    s_mode = M_NEVER;
    addr_i = 27'h0000500;
    sel_i  = 32'h0000_00FF;
    req_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_bus:cyc_before", wb_cyc_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_bus:wb_ctrl", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("rst_bus:ack_err_busy", {ack_o, err_o, busy_o}, 3'b000);
    check("rst_bus:adr_sel", {wb_adr_o, wb_sel_o}, 59'h0);
    check("rst_bus:data_o", data_o, 256'h0);
    req_i   = 1'b0;
    m_valid = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      check("rst_bus:no_ack", ack_o, 1'b0);
    end
    do_read("after_rst", 27'h0000500, 32'h0000_00FF, {8{$urandom()}}, 0, M_ACK, 0);

    // Randomized reads
    for (int i = 0; i < 10; i++) begin
      int mode;
      if ($urandom_range(0, 9) < 7) mode = M_ACK;
      else mode = ($urandom_range(0, 1) == 1) ? M_ERR : M_BOTH;
      do_read("random", 27'($urandom()), $urandom(), {8{$urandom()}},
              int'($urandom_range(0, 4)), mode, 0);
    end

    // Repeated line: a hit when the cache is built, two bus reads otherwise
    do_read("line40_first", 27'h0000040, $urandom(), {8{$urandom()}}, 1, M_ACK, 0);
    do_read("line40_again", 27'h0000040, $urandom(), {8{$urandom()}}, 1, M_ACK, 0);

    // Write notification for the line, then read it again
    @(negedge clk_i);
    inval_i      = 1'b1;
    inval_addr_i = 27'h0000040;
    @(negedge clk_i);
    inval_i = 1'b0;
    if (m_valid && m_tag == 27'h0000040) m_valid = 1'b0;
    do_read("line40_inval", 27'h0000040, $urandom(), {8{$urandom()}}, 0, M_ACK, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gfx256_zbuf_reader

// File: doc/gfx256_zbuf_reader.md
Name: gfx256_zbuf_reader

Overview:
- Responder end of the z-buffer read interface: `req_i`, `addr_i[31:5]`, `ack_o`, 256-bit `data_o`, `busy_o`.
- Serves the depth-test requester in the clipping stage.
- Each accepted request becomes one Wishbone classic read of a 256-bit memory line.
- Returns the line with a single-cycle ack and reports bus occupancy so the requester can hold off.

Parameters:
- `TIMEOUT_CYCLES`, 255: bus cycles allowed before an outstanding read is aborted; 0 disables the timeout.
- `TO_W`, 8: width of the timeout counter; must satisfy 2^`TO_W` > `TIMEOUT_CYCLES`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  read request; level, held by the requester until `ack_o`.
- `addr_i`  in  27 [31:5]  line address; stable while `req_i` is high.
- `sel_i`  in  32  byte selects forwarded to the bus.
- `ack_o`  out  1  one-cycle completion pulse; `data_o` is valid in the same cycle.
- `data_o`  out  256  returned line; holds its value until the next completion.
- `busy_o`  out  1  responder or bus occupied.
- `err_o`  out  1  one-cycle pulse coinciding with `ack_o` when the read failed.
- `bus_busy_i`  in  1  another master owns the bus.
- `wb_cyc_o`  out  1  Wishbone cycle.
- `wb_stb_o`  out  1  Wishbone strobe.
- `wb_we_o`  out  1  Wishbone write enable; constant 0.
- `wb_adr_o`  out  27 [31:5]  Wishbone line address.
- `wb_sel_o`  out  32  Wishbone byte selects.
- `wb_dat_i`  in  256  Wishbone read data.
- `wb_ack_i`  in  1  Wishbone acknowledge.
- `wb_err_i`  in  1  Wishbone error.
- `inval_i`  in  1  z-line write notification (used only with the optional feature).
- `inval_addr_i`  in  27 [31:5]  line address being written.

Behaviour:
- Reset (async, `rst_i`=1) puts every output to 0 (`ack_o`, `data_o`, `busy_o`, `err_o`, `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_adr_o`, `wb_sel_o`). State goes to `IDLE` and the timeout counter clears.
- `rst_i` during `BUS` drops `wb_cyc_o`/`wb_stb_o` immediately; no `ack_o` is issued.
- `busy_o` = (state != `IDLE`) | `bus_busy_i`, registered.
- States: `IDLE`, `BUS`, `DONE`.
- `IDLE`:
  - If `req_i` & ~`bus_busy_i`: latch `addr_i`/`sel_i` into `wb_adr_o`/`wb_sel_o`, set `wb_cyc_o`=`wb_stb_o`=1, clear the counter, go to `BUS`.
  - `req_i` while `bus_busy_i` waits in `IDLE`; the request is never dropped.
- `BUS`:
  - `wb_ack_i`: capture `wb_dat_i` into `data_o`, drop cyc/stb, set `ack_o`=1, go to `DONE`.
  - `wb_err_i` (takes priority over `wb_ack_i` if both are high): `data_o`=0, drop cyc/stb, set `ack_o`=1 and `err_o`=1, go to `DONE`.
  - Counter reaching `TIMEOUT_CYCLES` (when nonzero): same handling as `wb_err_i`.
  - Otherwise the counter increments.
- `DONE`:
  - `ack_o` and `err_o` are high for exactly this cycle; next state is `IDLE`.
  - `req_i` is ignored here, because the requester deasserts it on the edge where it samples `ack_o`.
  - This guard cycle prevents a duplicate read.
- Latency:
  - `req_i` sampled high at edge N gives `wb_cyc_o` high from N+1.
  - `wb_ack_i` sampled at edge K gives `ack_o` high in the cycle after K.
  - Minimum request-to-ack is 2 cycles with a zero-wait-state slave.
- Back-to-back requests: earliest re-acceptance is the edge after `DONE`. Minimum spacing from one `wb_cyc_o` rise to the next is 3 cycles.
- Error reads return 0. A z of 0 passes the depth test, so the pixel is drawn rather than silently dropped.
- `wb_we_o` is constantly 0.
- `inval_i` is ignored without the optional feature.

Optional Feature:
- Macro: `GFX256_ZREAD_LINE_CACHE_EN`.
- Enabled: a one-line cache holds a valid bit, the tag [31:5] and 256 data bits.
  - `IDLE` with `req_i` & valid & (`addr_i`==tag) is a hit: load cached data into `data_o` and go straight to `DONE`. Latency is 1 cycle, there is no bus cycle, and `bus_busy_i` is ignored on a hit.
  - Each successful bus read writes the tag and data and sets valid.
  - Error or timeout clears valid.
  - `inval_i` with `inval_addr_i`==tag clears valid. If this happens in the same cycle as a hit check, invalidation wins and the request goes to the bus.
  - Reset clears valid.
- Disabled: every request goes to the bus and `inval_i`/`inval_addr_i` are unused.

Decomposition:
- Shared package `gfx256_pkg` gets:
  - The state enum `zrd_state_t` (`IDLE`, `BUS`, `DONE`).
  - The constant `ZRD_ERR_DATA` (256'h0).
  - The typedef `line_addr_t` (logic [31:5]).
- The cache is a natural sub-module, `gfx256_zline_cache`, containing tag compare, valid, data and invalidate logic. It is instantiated only under the macro.

Test Plan:
- Single read, slave acks 3 cycles after `wb_cyc_o`, addr 27'h0000123, `wb_dat_i`=256'hA5…: `wb_adr_o`=27'h0000123 and `wb_sel_o`=32'hFFFFFFFF during the cycle; `ack_o` pulses exactly 1 cycle with `data_o`=256'hA5…; exactly one bus cycle per request.
- `req_i` raised while `bus_busy_i`=1 for 5 cycles: no `wb_cyc_o`; `busy_o`=1; `wb_cyc_o` rises the cycle after `bus_busy_i` falls.
- `wb_err_i` on first bus cycle: `ack_o`=`err_o`=1 for one cycle; `data_o`=0; `wb_cyc_o` low next cycle.
- Slave never acks, `TIMEOUT_CYCLES`=255: abort after 255 cycles; `ack_o`+`err_o` pulse; state returns to `IDLE`.
- `rst_i` pulsed while in `BUS`: all outputs 0 immediately; no `ack_o`; a new request afterwards completes normally.
- With `GFX256_ZREAD_LINE_CACHE_EN`:
  - Two reads of addr 27'h40: the second acks 1 cycle after request with no `wb_cyc_o`.
  - `inval_i` with addr 27'h40, then a read of 27'h40: the read issues a bus cycle.
